// File: rtl/match_priority_merge.sv
// Final stage of the four-subset classifier: a two-level compare tree picks the
// lowest matching rule ID, and saturating counters track searches and hits.
module match_priority_merge #(
   parameter int              ID_W    = 11,
   parameter int              CNT_W   = 16,
   parameter logic [ID_W-1:0] MISS_ID = {ID_W{1'b1}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [1:0]       command,
   input  logic [3:0]       subset_match,
   input  logic [ID_W-1:0]  match_ruleID0,
   input  logic [ID_W-1:0]  match_ruleID1,
   input  logic [ID_W-1:0]  match_ruleID2,
   input  logic [ID_W-1:0]  match_ruleID3,
   input  logic             cnt_clear,
   output logic             out_valid,
   output logic             match_reg,
   output logic [ID_W-1:0]  match_ruleID_reg,
   output logic [1:0]       match_subset,
   output logic [CNT_W-1:0] search_cnt,
   output logic [CNT_W-1:0] hit_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic            accept;
   logic            a_match, b_match;
   logic [ID_W-1:0] a_id, b_id;
   logic [1:0]      a_idx, b_idx;

   logic            s1_valid;
   logic            s1_a_match, s1_b_match;
   logic [ID_W-1:0] s1_a_id, s1_b_id;
   logic [1:0]      s1_a_idx, s1_b_idx;

   logic            fin_match;
   logic [ID_W-1:0] fin_id;
   logic [1:0]      fin_idx;

   assign accept = in_valid && (command == 2'b10);

   // First level: a matched candidate beats an unmatched one; ties go to the lower subset.
   always_comb begin
      a_match = 1'b0;
      a_id    = MISS_ID;
      a_idx   = 2'd0;
      if (subset_match[0] && (!subset_match[1] || (match_ruleID0 <= match_ruleID1))) begin
         a_match = 1'b1;
         a_id    = match_ruleID0;
         a_idx   = 2'd0;
      end else if (subset_match[1]) begin
         a_match = 1'b1;
         a_id    = match_ruleID1;
         a_idx   = 2'd1;
      end

      b_match = 1'b0;
      b_id    = MISS_ID;
      b_idx   = 2'd0;
      if (subset_match[2] && (!subset_match[3] || (match_ruleID2 <= match_ruleID3))) begin
         b_match = 1'b1;
         b_id    = match_ruleID2;
         b_idx   = 2'd2;
      end else if (subset_match[3]) begin
         b_match = 1'b1;
         b_id    = match_ruleID3;
         b_idx   = 2'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_a_match <= 1'b0;
         s1_a_id    <= MISS_ID;
         s1_a_idx   <= 2'd0;
         s1_b_match <= 1'b0;
         s1_b_id    <= MISS_ID;
         s1_b_idx   <= 2'd0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_a_match <= a_match;
            s1_a_id    <= a_id;
            s1_a_idx   <= a_idx;
            s1_b_match <= b_match;
            s1_b_id    <= b_id;
            s1_b_idx   <= b_idx;
         end
      end
   end

   // Second level: equal IDs resolve to pair A, which holds the lower subsets.
   always_comb begin
      fin_match = 1'b0;
      fin_id    = MISS_ID;
      fin_idx   = 2'd0;
      if (s1_a_match && (!s1_b_match || (s1_a_id <= s1_b_id))) begin
         fin_match = 1'b1;
         fin_id    = s1_a_id;
         fin_idx   = s1_a_idx;
      end else if (s1_b_match) begin
         fin_match = 1'b1;
         fin_id    = s1_b_id;
         fin_idx   = s1_b_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid        <= 1'b0;
         match_reg        <= 1'b0;
         match_ruleID_reg <= MISS_ID;
         match_subset     <= 2'd0;
      end else begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            match_reg        <= fin_match;
            match_ruleID_reg <= fin_id;
            match_subset     <= fin_idx;
         end
      end
   end

   // Counters account for the result being presented this cycle; a clear discards it.
   always_ff @(posedge clk) begin
      if (rst || cnt_clear) begin
         search_cnt <= '0;
         hit_cnt    <= '0;
      end else if (out_valid) begin
         if (search_cnt != {CNT_W{1'b1}}) begin
            search_cnt <= search_cnt + CNT_ONE;
         end
         if (match_reg && (hit_cnt != {CNT_W{1'b1}})) begin
            hit_cnt <= hit_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_match_priority_merge.sv
// Bench for match_priority_merge: vector table, directed corner sequences and
// random traffic, all checked against a cycle-stamped result queue model.
module tb_match_priority_merge;

   localparam int              ID_W    = 11;
   localparam int              CNT_W   = 16;
   localparam logic [ID_W-1:0] MISS    = 11'h7FF;
   localparam int              CNT_MAX = 65535;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic [1:0]       command;
   logic [3:0]       subset_match;
   logic [ID_W-1:0]  id0, id1, id2, id3;
   logic             cnt_clear;
   logic             out_valid;
   logic             match_reg;
   logic [ID_W-1:0]  match_ruleID_reg;
   logic [1:0]       match_subset;
   logic [CNT_W-1:0] search_cnt;
   logic [CNT_W-1:0] hit_cnt;

   match_priority_merge dut (
      .clk              (clk),
      .rst              (rst),
      .in_valid         (in_valid),
      .command          (command),
      .subset_match     (subset_match),
      .match_ruleID0    (id0),
      .match_ruleID1    (id1),
      .match_ruleID2    (id2),
      .match_ruleID3    (id3),
      .cnt_clear        (cnt_clear),
      .out_valid        (out_valid),
      .match_reg        (match_reg),
      .match_ruleID_reg (match_ruleID_reg),
      .match_subset     (match_subset),
      .search_cnt       (search_cnt),
      .hit_cnt          (hit_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int              due;
      logic            hit;
      logic [ID_W-1:0] id;
      logic [1:0]      sub;
   } pend_t;

   typedef struct {
      logic [3:0]            sm;
      logic [3:0][ID_W-1:0]  ids;
      logic                  e_hit;
      logic [ID_W-1:0]       e_id;
      logic [1:0]            e_sub;
   } vec_t;

   pend_t           pend[$];
   logic            m_valid = 1'b0;
   logic            m_hit   = 1'b0;
   logic [ID_W-1:0] m_id    = MISS;
   logic [1:0]      m_sub   = 2'd0;
   int              m_search = 0;
   int              m_hits   = 0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40)
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Winner = matched subset with the smallest ID, earliest subset on a tie.
   function automatic pend_t resolve(input logic [3:0] sm, input logic [3:0][ID_W-1:0] ids);
      pend_t r;
      r.due = 0;
      r.hit = 1'b0;
      r.id  = MISS;
      r.sub = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (sm[i] && (!r.hit || ids[i] < r.id)) begin
            r.hit = 1'b1;
            r.id  = ids[i];
            r.sub = 2'(i);
         end
      end
      return r;
   endfunction

   task automatic tick();
      pend_t nw;
      pend_t old;
      logic  acc;
      acc = in_valid && (command == 2'b10);
      nw  = resolve(subset_match, {id3, id2, id1, id0});
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
         pend.delete();
         m_valid  = 1'b0;
         m_hit    = 1'b0;
         m_id     = MISS;
         m_sub    = 2'd0;
         m_search = 0;
         m_hits   = 0;
      end else begin
         if (cnt_clear) begin
            m_search = 0;
            m_hits   = 0;
         end else if (m_valid) begin
            if (m_search < CNT_MAX) m_search++;
            if (m_hit && m_hits < CNT_MAX) m_hits++;
         end
         m_valid = 1'b0;
         if (pend.size() > 0 && pend[0].due == cyc) begin
            old     = pend.pop_front();
            m_valid = 1'b1;
            m_hit   = old.hit;
            m_id    = old.id;
            m_sub   = old.sub;
         end
         if (acc) begin
            nw.due = cyc + 1;
            pend.push_back(nw);
         end
      end
      check_output("model out_valid", out_valid, m_valid);
      check_output("model match_reg", match_reg, m_hit);
      check_output("model rule id", match_ruleID_reg, m_id);
      check_output("model subset", match_subset, m_sub);
      check_output("model search_cnt", search_cnt, m_search);
      check_output("model hit_cnt", hit_cnt, m_hits);
   endtask

   task automatic apply_stimulus(input logic v, input logic [1:0] cmd, input logic [3:0] sm,
                                 input logic [3:0][ID_W-1:0] ids, input logic clr);
      in_valid     = v;
      command      = cmd;
      subset_match = sm;
      id0          = ids[0];
      id1          = ids[1];
      id2          = ids[2];
      id3          = ids[3];
      cnt_clear    = clr;
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(1'b0, 2'b00, 4'b0000, '0, 1'b0);
   endtask

   function automatic vec_t mk(input logic [3:0] sm, input int i0, input int i1, input int i2,
                               input int i3, input logic eh, input int eid, input int esub);
      vec_t v;
      v.sm     = sm;
      v.ids[0] = ID_W'(i0);
      v.ids[1] = ID_W'(i1);
      v.ids[2] = ID_W'(i2);
      v.ids[3] = ID_W'(i3);
      v.e_hit  = eh;
      v.e_id   = ID_W'(eid);
      v.e_sub  = 2'(esub);
      return v;
   endfunction

   vec_t vecs[$];
   logic saw_valid;
   int   pulses, first_pulse, last_pulse, start_cyc, exp_search;

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; command = 2'b00; subset_match = 4'b0; cnt_clear = 1'b0;
      id0 = '0; id1 = '0; id2 = '0; id3 = '0;
      tick();
      tick();
      check_output("reset out_valid", out_valid, 1'b0);
      check_output("reset match_reg", match_reg, 1'b0);
      check_output("reset rule id", match_ruleID_reg, MISS);
      check_output("reset subset", match_subset, 2'd0);
      check_output("reset search_cnt", search_cnt, 16'd0);
      check_output("reset hit_cnt", hit_cnt, 16'd0);
      rst = 1'b0;
      idle(1);

      // Single hit, then the counters one cycle after the result
      apply_stimulus(1'b1, 2'b10, 4'b0100, {11'd1, 11'd37, 11'd1, 11'd1}, 1'b0);
      check_output("single not early", out_valid, 1'b0);
      idle(1);
      check_output("single out_valid", out_valid, 1'b1);
      check_output("single match", match_reg, 1'b1);
      check_output("single id", match_ruleID_reg, 11'd37);
      check_output("single subset", match_subset, 2'd2);
      idle(1);
      check_output("single search_cnt", search_cnt, 16'd1);
      check_output("single hit_cnt", hit_cnt, 16'd1);

      vecs.push_back(mk(4'b1111, 500, 12, 12, 900, 1'b1, 12, 1));
      vecs.push_back(mk(4'b1111, 7, 7, 7, 7, 1'b1, 7, 0));
      vecs.push_back(mk(4'b0000, 3, 4, 5, 6, 1'b0, 11'h7FF, 0));
      vecs.push_back(mk(4'b1000, 0, 0, 0, 5, 1'b1, 5, 3));
      vecs.push_back(mk(4'b1010, 1, 300, 1, 299, 1'b1, 299, 3));
      vecs.push_back(mk(4'b0011, 4, 3, 0, 0, 1'b1, 3, 1));
      vecs.push_back(mk(4'b1100, 0, 0, 9, 9, 1'b1, 9, 2));
      vecs.push_back(mk(4'b0110, 0, 20, 20, 0, 1'b1, 20, 1));
      vecs.push_back(mk(4'b0001, 0, 1, 1, 1, 1'b1, 0, 0));
      vecs.push_back(mk(4'b1101, 2047, 0, 2046, 2045, 1'b1, 2045, 3));
      foreach (vecs[k]) begin
         apply_stimulus(1'b1, 2'b10, vecs[k].sm, vecs[k].ids, 1'b0);
         idle(1);
         check_output($sformatf("vec%0d out_valid", k), out_valid, 1'b1);
         check_output($sformatf("vec%0d match", k), match_reg, vecs[k].e_hit);
         check_output($sformatf("vec%0d id", k), match_ruleID_reg, vecs[k].e_id);
         check_output($sformatf("vec%0d subset", k), match_subset, vecs[k].e_sub);
      end
      idle(2);

      // Non-search commands are ignored entirely
      exp_search = m_search;
      saw_valid = 1'b0;
      apply_stimulus(1'b1, 2'b01, 4'b1111, {11'd1, 11'd2, 11'd3, 11'd4}, 1'b0);
      saw_valid |= out_valid;
      apply_stimulus(1'b1, 2'b00, 4'b1111, {11'd1, 11'd2, 11'd3, 11'd4}, 1'b0);
      saw_valid |= out_valid;
      apply_stimulus(1'b1, 2'b11, 4'b1111, {11'd1, 11'd2, 11'd3, 11'd4}, 1'b0);
      saw_valid |= out_valid;
      for (int i = 0; i < 3; i++) begin
         idle(1);
         saw_valid |= out_valid;
      end
      check_output("ignored cmd out_valid", saw_valid, 1'b0);
      check_output("ignored cmd search_cnt", search_cnt, exp_search);

      // Ten back-to-back searches alternating hit and miss
      apply_stimulus(1'b0, 2'b00, 4'b0000, '0, 1'b1);
      pulses = 0; first_pulse = -1; last_pulse = -1;
      for (int k = 0; k < 10; k++) begin
         apply_stimulus(1'b1, 2'b10, (k % 2 == 0) ? 4'b0001 : 4'b0000,
                        {11'd0, 11'd0, 11'd0, 11'(k + 1)}, 1'b0);
         if (k == 0) start_cyc = cyc;
         if (out_valid) begin
            pulses++;
            if (first_pulse < 0) first_pulse = cyc;
            last_pulse = cyc;
         end
      end
      for (int i = 0; i < 4; i++) begin
         idle(1);
         if (out_valid) begin
            pulses++;
            last_pulse = cyc;
         end
      end
      check_output("stream pulses", pulses, 10);
      check_output("stream latency", first_pulse, start_cyc + 1);
      check_output("stream contiguous", last_pulse - first_pulse, 9);
      check_output("stream search_cnt", search_cnt, 16'd10);
      check_output("stream hit_cnt", hit_cnt, 16'd5);

      // Saturation of both counters
      apply_stimulus(1'b0, 2'b00, 4'b0000, '0, 1'b1);
      for (int k = 0; k < CNT_MAX + 5; k++)
         apply_stimulus(1'b1, 2'b10, 4'b0001, {11'd0, 11'd0, 11'd0, 11'd3}, 1'b0);
      idle(3);
      check_output("sat search_cnt", search_cnt, 16'hFFFF);
      check_output("sat hit_cnt", hit_cnt, 16'hFFFF);
      apply_stimulus(1'b1, 2'b10, 4'b0010, {11'd0, 11'd0, 11'd8, 11'd0}, 1'b0);
      idle(3);
      check_output("sat hold search_cnt", search_cnt, 16'hFFFF);
      check_output("sat hold hit_cnt", hit_cnt, 16'hFFFF);

      // Clear on the same cycle as a completing search wins
      apply_stimulus(1'b1, 2'b10, 4'b0001, {11'd0, 11'd0, 11'd0, 11'd4}, 1'b0);
      idle(1);
      check_output("clear coincide valid", out_valid, 1'b1);
      apply_stimulus(1'b0, 2'b00, 4'b0000, '0, 1'b1);
      check_output("clear search_cnt", search_cnt, 16'd0);
      check_output("clear hit_cnt", hit_cnt, 16'd0);
      idle(2);

      // Reset while two searches are in flight
      apply_stimulus(1'b1, 2'b10, 4'b0001, {11'd0, 11'd0, 11'd0, 11'd5}, 1'b0);
      apply_stimulus(1'b1, 2'b10, 4'b0010, {11'd0, 11'd0, 11'd6, 11'd0}, 1'b0);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      saw_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idle(1);
         saw_valid |= out_valid;
      end
      check_output("midreset out_valid", saw_valid, 1'b0);
      check_output("midreset match", match_reg, 1'b0);
      check_output("midreset id", match_ruleID_reg, MISS);
      check_output("midreset subset", match_subset, 2'd0);
      check_output("midreset search_cnt", search_cnt, 16'd0);

      // Random traffic against the model
      for (int k = 0; k < 600; k++) begin
         logic [3:0][ID_W-1:0] rids;
         logic [1:0] cmd;
         for (int j = 0; j < 4; j++)
            rids[j] = ($urandom_range(0, 1) == 0) ? ID_W'($urandom_range(0, 15)) : ID_W'($urandom);
         cmd = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b10;
         rst = ($urandom_range(0, 149) == 0);
         apply_stimulus(1'($urandom), cmd, 4'($urandom), rids, ($urandom_range(0, 29) == 0));
      end
      rst = 1'b0;
      idle(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
